cr_quantizer: RTL and testbench

CR_QUANTIZER -- requirements
Module: cr_quantizer

---
 rtl/cr_quantizer.sv | 105 ++++++++++
 tb/tb_cr_quantizer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cr_quantizer.sv
// Cr-channel JPEG quantizer: one 8x8 block of signed 11-bit DCT coefficients
// is accepted per enabled cycle and quantized in parallel through a 3-stage
// pipeline (register Z, register products, register rounded Q).
// Division by the chroma table is replaced by multiplication with the
// constant reciprocal floor(4096/Qtab) followed by a rounding 12-bit shift.
module cr_quantizer (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic signed [10:0] Z [0:7][0:7],
  output logic signed [10:0] Q [0:7][0:7],
  output logic               out_enable
);

  // Reciprocals of the standard JPEG chroma table, floor(4096/Qtab).
  //   17->240 18->227 21->195 24->170 26->157 47->87 56->73 66->62 99->41
  localparam logic [7:0] QQ [0:7][0:7] = '{
    '{8'd240, 8'd227, 8'd170, 8'd87, 8'd41, 8'd41, 8'd41, 8'd41},
    '{8'd227, 8'd195, 8'd157, 8'd62, 8'd41, 8'd41, 8'd41, 8'd41},
    '{8'd170, 8'd157, 8'd73,  8'd41, 8'd41, 8'd41, 8'd41, 8'd41},
    '{8'd87,  8'd62,  8'd41,  8'd41, 8'd41, 8'd41, 8'd41, 8'd41},
    '{8'd41,  8'd41,  8'd41,  8'd41, 8'd41, 8'd41, 8'd41, 8'd41},
    '{8'd41,  8'd41,  8'd41,  8'd41, 8'd41, 8'd41, 8'd41, 8'd41},
    '{8'd41,  8'd41,  8'd41,  8'd41, 8'd41, 8'd41, 8'd41, 8'd41},
    '{8'd41,  8'd41,  8'd41,  8'd41, 8'd41, 8'd41, 8'd41, 8'd41}
  };

  // Stage 1: captured coefficients and their valid bit.
  logic signed [10:0] z_r    [0:7][0:7];
  logic               v1;
  // Stage 2: 22-bit two's-complement products and their valid bit.
  logic        [21:0] prod_r [0:7][0:7];
  logic               v2;

  // Signed 11-bit coefficient times unsigned 8-bit reciprocal. Both operands
  // are extended to 22 bits (sign for Z, zero for qq); the low 22 bits of an
  // unsigned multiply equal the signed product, which always fits.
  function automatic logic [21:0] mul_qq(input logic signed [10:0] z,
                                         input logic        [7:0]  qq);
    return {{11{z[10]}}, z} * {14'd0, qq};
  endfunction

  // (p >>> 12) + p[11], truncated to 11 bits. The shifted value truncated
  // to 11 bits is {p[21], p[21:12]}; adding bit 11 rounds half up.
  function automatic logic signed [10:0] round_q(input logic [21:0] p);
    return {p[21], p[21:12]} + {10'd0, p[11]};
  endfunction

  // Stage 1: capture Z only on enabled cycles; valid follows enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: every pipeline register, including the 64-entry arrays, is
      // cleared so that a reset visibly zeroes Q and drops in-flight blocks.
      v1 <= 1'b0;
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++)
          z_r[i][j] <= '0;
    end else begin
      // NOTE: non-blocking assignments everywhere in clocked blocks so each
      // stage reads the previous stage's value from before this edge.
      v1 <= enable;
      if (enable) begin
        for (int i = 0; i < 8; i++)
          for (int j = 0; j < 8; j++)
            z_r[i][j] <= Z[i][j];
      end
    end
  end

  // Stage 2: multiply every captured coefficient by its reciprocal.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2 <= 1'b0;
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++)
          prod_r[i][j] <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        for (int i = 0; i < 8; i++)
          for (int j = 0; j < 8; j++)
            prod_r[i][j] <= mul_qq(z_r[i][j], QQ[i][j]);
      end
    end
  end

  // Stage 3: round and publish; Q only changes together with out_enable,
  // so it holds the last result while out_enable is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_enable <= 1'b0;
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++)
          Q[i][j] <= '0;
    end else begin
      out_enable <= v2;
      if (v2) begin
        for (int i = 0; i < 8; i++)
          for (int j = 0; j < 8; j++)
            Q[i][j] <= round_q(prod_r[i][j]);
      end
    end
  end

endmodule

// File: tb/tb_cr_quantizer.sv
// Directed bench for cr_quantizer. Expected values are hand-computed from
// Q = floor(Z*qq / 4096) + bit11(Z*qq), with qq = floor(4096/Qtab).
module tb_cr_quantizer;

  logic               clk;
  logic               rst;
  logic               enable;
  logic signed [10:0] z [0:7][0:7];
  logic signed [10:0] q [0:7][0:7];
  logic               out_enable;

  int n_tests = 0;
  int n_fail  = 0;

  cr_quantizer dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .Z          (z),
    .Q          (q),
    .out_enable (out_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        z[i][j] = 11'(v);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        z[i][j] = 11'(8 * i + j);
  endtask

  task automatic fill_checker();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        z[i][j] = ((i + j) % 2 == 0) ? 11'sd1023 : -11'sd1024;
  endtask

  // One enabled cycle, then confirm out_enable appears on the third edge
  // (counting the sampling edge) and lasts exactly one cycle.
  task automatic run_block(input string tag);
    @(negedge clk) enable = 1'b1;
    @(posedge clk) #1;
    check({tag, "_oe_edge1"}, out_enable, 0);
    @(negedge clk) enable = 1'b0;
    @(posedge clk) #1;
    check({tag, "_oe_edge2"}, out_enable, 0);
    @(posedge clk) #1;
    check({tag, "_oe_edge3"}, out_enable, 1);
    @(posedge clk) #1;
    check({tag, "_oe_edge4"}, out_enable, 0);
  endtask

  // Expected row 0 for all-1023 input: 1023*qq = 245520, 232221, 173910,
  // 89001, 41943 -> 60, 57, 42 (bit 11 clear), 22, 10.
  int row0_max [0:7] = '{60, 57, 42, 22, 10, 10, 10, 10};
  int pulses;

  initial begin
    rst    = 1'b0;
    enable = 1'b0;
    fill_const(0);
    #12;
    check("rst_q00", q[0][0], 0);
    check("rst_q77", q[7][7], 0);
    check("rst_oe", out_enable, 0);
    @(negedge clk) rst = 1'b1;

    // All 1023.
    fill_const(1023);
    run_block("max");
    for (int j = 0; j < 8; j++)
      check($sformatf("max_q0%0d", j), q[0][j], row0_max[j]);
    check("max_q11", q[1][1], 49);
    check("max_q22", q[2][2], 18);
    check("max_q47", q[4][7], 10);
    check("max_q77", q[7][7], 10);

    // Z ignored while enable is low: Q holds, no pulse.
    @(negedge clk) fill_const(-500);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk) #1;
      if (out_enable) pulses++;
    end
    check("idle_pulses", pulses, 0);
    check("idle_hold_q00", q[0][0], 60);

    // Ramp: 227 -> 0, 24*87=2088 -> 0+1, 63*41=2583 -> 0+1.
    fill_ramp();
    run_block("ramp");
    check("ramp_q00", q[0][0], 0);
    check("ramp_q01", q[0][1], 0);
    check("ramp_q30", q[3][0], 1);
    check("ramp_q77", q[7][7], 1);

    // Checkerboard: -232448 -> -57+0, -41984 -> -11+1.
    fill_checker();
    run_block("chk");
    check("chk_q00", q[0][0], 60);
    check("chk_q01", q[0][1], -57);
    check("chk_q07", q[0][7], -10);
    check("chk_q77", q[7][7], 10);

    // Z = -1: -240 and -41 both give -1 + 1 = 0.
    fill_const(-1);
    run_block("neg1");
    check("neg1_q00", q[0][0], 0);
    check("neg1_q77", q[7][7], 0);

    // Z = -1024: -245760 -> -60 exactly; -41984 -> -10.
    fill_const(-1024);
    run_block("min");
    check("min_q00", q[0][0], -60);
    check("min_q77", q[7][7], -10);

    // Back-to-back A (all 1023), B (ramp), C (checkerboard); watch Q[0][1].
    @(negedge clk) begin fill_const(1023); enable = 1'b1; end
    @(posedge clk) #1;
    check("b2b_oe_e1", out_enable, 0);
    @(negedge clk) fill_ramp();
    @(posedge clk) #1;
    check("b2b_oe_e2", out_enable, 0);
    @(negedge clk) fill_checker();
    @(posedge clk) #1;
    check("b2b_oe_a", out_enable, 1);
    check("b2b_q01_a", q[0][1], 57);
    @(negedge clk) enable = 1'b0;
    @(posedge clk) #1;
    check("b2b_oe_b", out_enable, 1);
    check("b2b_q01_b", q[0][1], 0);
    @(posedge clk) #1;
    check("b2b_oe_c", out_enable, 1);
    check("b2b_q01_c", q[0][1], -57);
    @(posedge clk) #1;
    check("b2b_oe_end", out_enable, 0);
    check("b2b_hold_q01", q[0][1], -57);

    // Reset one cycle after enable: immediate clear, no late pulse.
    @(negedge clk) begin fill_const(1023); enable = 1'b1; end
    @(posedge clk) #1;
    @(negedge clk) begin enable = 1'b0; rst = 1'b0; end
    #1;
    check("rstmid_q00", q[0][0], 0);
    check("rstmid_q01", q[0][1], 0);
    check("rstmid_oe", out_enable, 0);
    @(negedge clk) rst = 1'b1;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk) #1;
      if (out_enable) pulses++;
    end
    check("rstmid_no_pulse", pulses, 0);
    check("rstmid_hold_q00", q[0][0], 0);

    // Operation resumes after reset.
    fill_const(1023);
    run_block("resume");
    check("resume_q00", q[0][0], 60);
    check("resume_q22", q[2][2], 18);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
